// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and the
// pure decode function mapping an instruction to its source/destination IDs.
package y86_pkg;

  localparam int WORD_W_DEF = 64;
  localparam int NREGS_DEF  = 15;
  localparam int ID_W       = 4;

  localparam logic [ID_W-1:0] RNONE = 4'hF;
  localparam logic [ID_W-1:0] RRSP  = 4'h4;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef struct packed {
    logic [ID_W-1:0] src_a;
    logic [ID_W-1:0] src_b;
    logic [ID_W-1:0] dst_e;
    logic [ID_W-1:0] dst_m;
  } dec_ids_t;

  function automatic dec_ids_t decode_ids(
    input logic [3:0]      icode,
    input logic [ID_W-1:0] ra,
    input logic [ID_W-1:0] rb,
    input logic            cnd
  );
    dec_ids_t d;
    d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      I_HALT, I_NOP, I_JXX: begin
        d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
      end
      // cmovXX only writes its destination when the condition held
      I_RRMOVQ: begin
        d.src_a = ra;
        d.dst_e = cnd ? rb : RNONE;
      end
      I_IRMOVQ: begin
        d.dst_e = rb;
      end
      I_RMMOVQ: begin
        d.src_a = ra;
        d.src_b = rb;
      end
      I_MRMOVQ: begin
        d.src_b = rb;
        d.dst_m = ra;
      end
      I_OPQ: begin
        d.src_a = ra;
        d.src_b = rb;
        d.dst_e = rb;
      end
      I_CALL: begin
        d.src_b = RRSP;
        d.dst_e = RRSP;
      end
      I_RET: begin
        d.src_a = RRSP;
        d.src_b = RRSP;
        d.dst_e = RRSP;
      end
      I_PUSHQ: begin
        d.src_a = ra;
        d.src_b = RRSP;
        d.dst_e = RRSP;
      end
      I_POPQ: begin
        d.src_a = RRSP;
        d.src_b = RRSP;
        d.dst_e = RRSP;
        d.dst_m = ra;
      end
      default: begin
        d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register array: two asynchronous read ports, E and M write
// ports committed on the clock edge (M wins on a collision), async clear.
module regfile
  import y86_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   rd_a_id,
  input  logic [ID_W-1:0]   rd_b_id,
  output logic [WORD_W-1:0] rd_a_data,
  output logic [WORD_W-1:0] rd_b_data,
  input  logic              we_e,
  input  logic [ID_W-1:0]   wr_e_id,
  input  logic [WORD_W-1:0] wr_e_data,
  input  logic              we_m,
  input  logic [ID_W-1:0]   wr_m_id,
  input  logic [WORD_W-1:0] wr_m_data
);

  localparam logic [ID_W-1:0] ID_LIMIT = ID_W'(NREGS);

  logic [WORD_W-1:0] regs_q [NREGS];
  logic [WORD_W-1:0] regs_d [NREGS];

  // Next-state of each register; the M port is tested first so it overrides E.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (we_m && (wr_m_id == ID_W'(i))) begin
        regs_d[i] = wr_m_data;
      end else if (we_e && (wr_e_id == ID_W'(i))) begin
        regs_d[i] = wr_e_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: out-of-range IDs (including RNONE) and reset read as zero.
  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    if (!rst && (rd_a_id < ID_LIMIT)) begin
      rd_a_data = regs_q[rd_a_id];
    end else begin
      rd_a_data = '0;
    end
    if (!rst && (rd_b_id < ID_LIMIT)) begin
      rd_b_data = regs_q[rd_b_id];
    end else begin
      rd_b_data = '0;
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode and writeback stage: combinational register-ID decode and
// operand read, edge-committed register writeback and a retired-instruction count.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valM,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [WORD_W-1:0] valA,
  output logic [WORD_W-1:0] valB,
  output logic [WORD_W-1:0] retired
);

  dec_ids_t          ids_s;
  logic              we_e_s;
  logic              we_m_s;
  logic [WORD_W-1:0] retired_d;
  logic [WORD_W-1:0] retired_q;

  // Register-ID decode.
  always_comb begin
    ids_s = decode_ids(icode, rA, rB, cnd);
  end

  assign srcA    = ids_s.src_a;
  assign srcB    = ids_s.src_b;
  assign dstE    = ids_s.dst_e;
  assign dstM    = ids_s.dst_m;
  assign retired = retired_q;

  // Write enables and retired-count next state for this commit.
  always_comb begin
    we_e_s    = 1'b0;
    we_m_s    = 1'b0;
    retired_d = retired_q;
    if (wb_en) begin
      we_e_s    = (ids_s.dst_e != RNONE);
      we_m_s    = (ids_s.dst_m != RNONE);
      retired_d = retired_q + WORD_W'(1);
    end else begin
      we_e_s    = 1'b0;
      we_m_s    = 1'b0;
      retired_d = retired_q;
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  regfile #(
    .WORD_W (WORD_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_a_id   (ids_s.src_a),
    .rd_b_id   (ids_s.src_b),
    .rd_a_data (valA),
    .rd_b_data (valB),
    .we_e      (we_e_s),
    .wr_e_id   (ids_s.dst_e),
    .wr_e_data (valE),
    .we_m      (we_m_s),
    .wr_m_id   (ids_s.dst_m),
    .wr_m_data (valM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: decode vector table, directed
// writeback sequences, randomized traffic against a behavioural model, counter wrap.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  t_icode = 4'h1, t_ra = 4'hF, t_rb = 4'hF;
  logic        t_cnd = 1'b0, t_wb = 1'b0;
  logic [63:0] t_vale = 64'h0, t_valm = 64'h0;
  logic [3:0]  d_srca, d_srcb, d_dste, d_dstm;
  logic [63:0] d_vala, d_valb, d_ret;

  logic        w_wb = 1'b0;
  logic [3:0]  w_srca, w_srcb, w_dste, w_dstm;
  logic [7:0]  w_vala, w_valb, w_ret;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [15];
  logic [63:0] m_ret;

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk(clk), .rst(rst), .icode(t_icode), .rA(t_ra), .rB(t_rb), .cnd(t_cnd),
    .valE(t_vale), .valM(t_valm), .wb_en(t_wb),
    .srcA(d_srca), .srcB(d_srcb), .dstE(d_dste), .dstM(d_dstm),
    .valA(d_vala), .valB(d_valb), .retired(d_ret)
  );

  decode_writeback #(.WORD_W(8)) dut8 (
    .clk(clk), .rst(rst), .icode(4'h1), .rA(4'hF), .rB(4'hF), .cnd(1'b0),
    .valE(8'h00), .valM(8'h00), .wb_en(w_wb),
    .srcA(w_srca), .srcB(w_srcb), .dstE(w_dste), .dstM(w_dstm),
    .valA(w_vala), .valB(w_valb), .retired(w_ret)
  );

  // Reference decode written from the instruction-class rules.
  function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction
  function automatic logic [63:0] m_read(input logic [3:0] id);
    return (id == 4'hF) ? 64'h0 : m_regs[id];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm, input logic wb);
    t_icode = ic; t_ra = ra; t_rb = rb; t_cnd = c; t_vale = ve; t_valm = vm; t_wb = wb;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
    m_ret = 64'h0;
  endtask

  // One clock edge; the model commits what the DUT sees at that edge (E then M, so M wins).
  task automatic step();
    logic [3:0] e, m;
    if (t_wb) begin
      e = m_dste(t_icode, t_rb, t_cnd);
      m = m_dstm(t_icode, t_ra);
      if (e != 4'hF) m_regs[e] = t_vale;
      if (m != 4'hF) m_regs[m] = t_valm;
      m_ret = m_ret + 64'h1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_ids(input string tag);
    check({tag, ".srcA"}, {60'h0, d_srca}, {60'h0, m_srca(t_icode, t_ra)});
    check({tag, ".srcB"}, {60'h0, d_srcb}, {60'h0, m_srcb(t_icode, t_rb)});
    check({tag, ".dstE"}, {60'h0, d_dste}, {60'h0, m_dste(t_icode, t_rb, t_cnd)});
    check({tag, ".dstM"}, {60'h0, d_dstm}, {60'h0, m_dstm(t_icode, t_ra)});
  endtask

  task automatic check_reads(input string tag);
    check({tag, ".valA"}, d_vala, m_read(m_srca(t_icode, t_ra)));
    check({tag, ".valB"}, d_valb, m_read(m_srcb(t_icode, t_rb)));
  endtask

  // Read every register through the opq read ports without committing.
  task automatic sweep(input string tag);
    for (int r = 0; r < 15; r++) begin
      drive(4'h6, 4'(r), 4'(r), 1'b0, 64'h0, 64'h0, 1'b0);
      #1;
      check($sformatf("%s.reg%0d", tag, r), d_vala, m_regs[r]);
    end
  endtask

  typedef struct {
    logic [3:0] ic, ra, rb;
    logic       c;
    logic [3:0] sa, sb, de, dm;
  } dvec_t;

  initial begin
    dvec_t tbl [14];
    tbl[0]  = '{4'h0, 4'h1, 4'h2, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
    tbl[1]  = '{4'h2, 4'h1, 4'h3, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF};
    tbl[2]  = '{4'h2, 4'h1, 4'h3, 1'b1, 4'h1, 4'hF, 4'h3, 4'hF};
    tbl[3]  = '{4'h3, 4'hF, 4'h2, 1'b0, 4'hF, 4'hF, 4'h2, 4'hF};
    tbl[4]  = '{4'h4, 4'h5, 4'h6, 1'b0, 4'h5, 4'h6, 4'hF, 4'hF};
    tbl[5]  = '{4'h5, 4'h7, 4'h8, 1'b0, 4'hF, 4'h8, 4'hF, 4'h7};
    tbl[6]  = '{4'h6, 4'h9, 4'hA, 1'b1, 4'h9, 4'hA, 4'hA, 4'hF};
    tbl[7]  = '{4'h7, 4'h1, 4'h1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    tbl[8]  = '{4'h8, 4'hF, 4'hF, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF};
    tbl[9]  = '{4'h9, 4'hF, 4'hF, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF};
    tbl[10] = '{4'hA, 4'h3, 4'hF, 1'b0, 4'h3, 4'h4, 4'h4, 4'hF};
    tbl[11] = '{4'hB, 4'h4, 4'hF, 1'b0, 4'h4, 4'h4, 4'h4, 4'h4};
    tbl[12] = '{4'hC, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    tbl[13] = '{4'hF, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};

    model_clear();

    // Reset state, including a commit attempt while reset is held.
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'h55, 64'h0, 1'b1);
    #2;
    check("rst.retired", d_ret, 64'h0);
    check("rst.valA", d_vala, 64'h0);
    check("rst.retired8", {56'h0, w_ret}, 64'h0);
    @(posedge clk);
    #6;
    rst = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    sweep("after_rst");

    // Decode vector table.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ic, tbl[i].ra, tbl[i].rb, tbl[i].c, 64'h0, 64'h0, 1'b0);
      #1;
      check($sformatf("tbl%0d.srcA", i), {60'h0, d_srca}, {60'h0, tbl[i].sa});
      check($sformatf("tbl%0d.srcB", i), {60'h0, d_srcb}, {60'h0, tbl[i].sb});
      check($sformatf("tbl%0d.dstE", i), {60'h0, d_dste}, {60'h0, tbl[i].de});
      check($sformatf("tbl%0d.dstM", i), {60'h0, d_dstm}, {60'h0, tbl[i].dm});
    end
    @(posedge clk);
    #1;

    // irmovq $0x1234, %rdx
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1);
    #1;
    check("irmovq.dstE", {60'h0, d_dste}, 64'h2);
    check("irmovq.dstM", {60'h0, d_dstm}, 64'hF);
    step();
    check("irmovq.retired", d_ret, 64'h1);
    drive(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
    #1;
    check("irmovq.reg2", d_vala, 64'h1234);

    // cmov not taken then taken.
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h3333, 64'h0, 1'b1);
    step();
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'h5555, 64'h0, 1'b1);
    #1;
    check("cmov0.dstE", {60'h0, d_dste}, 64'hF);
    step();
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0);
    #1;
    check("cmov0.reg3", d_vala, 64'h3333);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'h5555, 64'h0, 1'b1);
    step();
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0);
    #1;
    check("cmov1.reg3", d_vala, 64'h5555);

    // popq %rsp: M beats E on the same register.
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hDEAD, 1'b1);
    step();
    drive(4'h6, 4'h4, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0);
    #1;
    check("popq_rsp.reg4", d_vala, 64'hDEAD);

    // Read-after-write in the same cycle sees the old value until the edge.
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0, 1'b1);
    step();
    drive(4'h6, 4'h5, 4'h5, 1'b0, 64'hABCD, 64'h0, 1'b1);
    #1;
    check("raw.old_valA", d_vala, 64'h55);
    check("raw.old_valB", d_valb, 64'h55);
    step();
    check("raw.new_valA", d_vala, 64'hABCD);
    check("raw.new_valB", d_valb, 64'hABCD);

    // wb_en low: nothing changes.
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h999, 64'h0, 1'b0);
    step();
    check("nowb.retired", d_ret, m_ret);
    // Writes to RNONE and an invalid icode with wb_en high.
    drive(4'h3, 4'hF, 4'hF, 1'b0, 64'hBAD, 64'h0, 1'b1);
    step();
    drive(4'hC, 4'h1, 4'h2, 1'b1, 64'hBAD1, 64'hBAD2, 1'b1);
    #1;
    check_ids("icodeC");
    step();
    check("icodeC.retired", d_ret, m_ret);
    sweep("directed");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) != 0));
      #1;
      check_ids("rand");
      check_reads("rand");
      step();
      check("rand.retired", d_ret, m_ret);
    end
    sweep("random");

    // Mid-cycle reset after writes clears everything before the next edge.
    drive(4'h6, 4'h2, 4'h4, 1'b0, 64'h77, 64'h0, 1'b1);
    #4;
    rst = 1'b1;
    #1;
    check("midrst.retired", d_ret, 64'h0);
    check("midrst.valA", d_vala, 64'h0);
    check("midrst.valB", d_valb, 64'h0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    model_clear();
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    #1;
    check("midrst.retired_after", d_ret, 64'h0);
    sweep("midrst");

    // Retired counter wrap on the narrow instance.
    @(posedge clk);
    #1;
    check("wrap.start", {56'h0, w_ret}, 64'h0);
    w_wb = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    check("wrap.allones", {56'h0, w_ret}, 64'hFF);
    @(posedge clk);
    #1;
    check("wrap.zero", {56'h0, w_ret}, 64'h0);
    w_wb = 1'b0;
    @(posedge clk);
    #1;
    check("wrap.hold", {56'h0, w_ret}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 Parameter: WORD_W, default 64, data word width of registers and values.
REQ-002 Parameter: NREGS, default 15, number of architectural registers (IDs 0x0-0xE); ID 0xF is RNONE.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 icode  input  4  instruction code from fetch stage.
REQ-006 rA  input  4  register specifier A from fetch.
REQ-007 rB  input  4  register specifier B from fetch.
REQ-008 cnd  input  1  condition result from execute; qualifies cmovXX writes.
REQ-009 valE  input  WORD_W  execute result to write back.
REQ-010 valM  input  WORD_W  memory read data to write back.
REQ-011 wb_en  input  1  one-cycle strobe: commit this instruction's writes at the next rising edge.
REQ-012 srcA, srcB, dstE, dstM  output  4 each  decoded register IDs.
REQ-013 valA, valB  output  WORD_W each  register read data for srcA/srcB.
REQ-014 retired  output  WORD_W  count of committed instructions.

Function
REQ-015 srcA SHALL be rA for icode 2,4,6,A; 0x4 (%rsp) for icode 9,B; else 0xF.
REQ-016 srcB SHALL be rB for icode 4,5,6; 0x4 for icode 8,9,A,B; else 0xF.
REQ-017 dstE SHALL be rB for icode 3,6; rB for icode 2 only when cnd=1, else 0xF; 0x4 for icode 8,9,A,B; else 0xF.
REQ-018 dstM SHALL be rA for icode 5,B; else 0xF.
REQ-019 Decode outputs SHALL be combinational in icode/rA/rB/cnd; icode > 0xB SHALL yield all four IDs = 0xF.
REQ-020 valA/valB SHALL be combinational reads of current register state; ID 0xF SHALL read 0.
REQ-021 No write-to-read bypass: a write committed at edge N is visible on valA/valB only after edge N.
REQ-022 On a rising edge with wb_en=1, reg[dstE] <= valE when dstE != 0xF, and reg[dstM] <= valM when dstM != 0xF.
REQ-023 If dstE == dstM != 0xF on the same edge, valM SHALL win (popq %rsp semantics).
REQ-024 Writes to ID 0xF SHALL be discarded with no side effect on any register.
REQ-025 wb_en=0 SHALL leave all registers and retired unchanged regardless of other inputs.
REQ-026 retired SHALL increment by 1 on each edge with wb_en=1, wrapping from all-ones to 0.
REQ-027 Latency: decode 0 cycles (combinational); writeback commits 1 edge after wb_en sampled high.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, clear all registers and retired to 0.
REQ-029 While rst=1, wb_en SHALL be ignored; valA/valB SHALL read 0 for every source ID.
REQ-030 Reset asserted coincident with a wb_en edge SHALL win; that write SHALL be lost.
REQ-031 Decode ID outputs are not reset; they track inputs combinationally at all times.

Structure
REQ-032 Shared package y86_pkg SHALL hold icode constants (HALT..POPQ), RNONE=0xF, RRSP=0x4 and WORD_W default.
REQ-033 One sub-module regfile SHALL hold the register array: two async read ports, two write ports with M-over-E priority, async reset.
REQ-034 decode_writeback SHALL contain decode logic, the retired counter and one regfile instance.

Verification
REQ-035 Reset: pulse rst mid-cycle after writes -> all registers read 0 and retired=0 before next edge.
REQ-036 irmovq: icode=3, rB=2, valE=0x1234, wb_en=1 -> after edge reg2=0x1234; dstE=2, dstM=0xF, retired=1.
REQ-037 cmov: icode=2, rA=1, rB=3, cnd=0, wb_en=1 -> dstE=0xF, reg3 unchanged; repeat with cnd=1 -> reg3=valE.
REQ-038 popq %rsp: icode=B, rA=4, valE=0x100, valM=0xDEAD, wb_en=1 -> reg4=0xDEAD after edge.
REQ-039 Read-after-write same cycle: opq rA=rB=5 with wb_en writing reg5 -> valA/valB show old value until edge, new value after.
REQ-040 Counter wrap: force retired to all-ones via 2^WORD_W-1 commits (or preload in bench) -> next wb_en edge gives 0; invalid icode=0xC -> all IDs 0xF, no register change.
